// File: rtl/ifu_pkg.sv
// Shared fetch-unit types: global widths, fetch-queue depth and queue entry layout.
package ifu_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned INSTR_LEN    = 32;
  localparam int unsigned IFU_FQ_DEPTH = 2;

  typedef struct packed {
    logic [INSTR_LEN-1:0] instr;
    logic [XLEN-1:0]      tag;
  } ifu_fq_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] ifu_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_if.sv
// Fetch-unit bus bundle: instruction-memory request/response plus the decode-side port.
interface ifu_if;
  import ifu_pkg::*;

  logic                 imem_req_valid;
  logic [XLEN-1:0]      imem_req_addr;
  logic                 imem_req_ready;
  logic                 imem_rsp_valid;
  logic [INSTR_LEN-1:0] imem_rsp_data;
  logic                 pipe_stall;
  logic                 pipe_flush;
  logic [XLEN-1:0]      flush_pc;
  logic [INSTR_LEN-1:0] instr;
  logic                 instr_valid;
  logic [XLEN-1:0]      instr_tag;

  modport master (
    output imem_req_valid, imem_req_addr, instr, instr_valid, instr_tag,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, pipe_stall, pipe_flush, flush_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr, instr_valid, instr_tag,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, pipe_stall, pipe_flush, flush_pc
  );

endinterface

// File: rtl/ifu_fetch_queue.sv
// Shifting fetch queue: entry 0 is always the head, so the head is a plain register.
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter  int unsigned DEPTH = IFU_FQ_DEPTH,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  ifu_fq_entry_t push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output ifu_fq_entry_t head
);

  ifu_fq_entry_t mem_q [DEPTH];
  ifu_fq_entry_t mem_d [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] wr_idx;
  logic          do_pop;
  logic          do_push;

  // Next-state: shift on pop, write behind the surviving entries on push; flush empties.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_idx  = count_q - CW'(do_pop);
    if (do_pop) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
    end
    if (do_push) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (CW'(i) == wr_idx) begin
          mem_d[i] = push_data;
        end
      end
    end
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Queue storage and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[0];

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: credit-limited PC fetch, in-order tag matching, flush with stale-response drop.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned     FQ_DEPTH     = IFU_FQ_DEPTH
) (
  input logic   clk,
  input logic   rstn,
  ifu_if.master bus
);

  localparam int unsigned CW  = $clog2(FQ_DEPTH + 1);
  localparam int unsigned CW1 = CW + 1;
  localparam int unsigned PW  = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;

  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   outstanding_q;
  logic [CW-1:0]   drop_q;
  logic [CW-1:0]   outstanding_rsp;
  logic [CW-1:0]   fq_count;
  logic [XLEN-1:0] tag_mem_q [FQ_DEPTH];
  logic [PW-1:0]   tag_wr_q;
  logic [PW-1:0]   tag_rd_q;
  logic            credit;
  logic            req_valid;
  logic            req_fire;
  logic            rsp_drop;
  logic            fq_push;
  logic            fq_pop;
  ifu_fq_entry_t   fq_push_data;
  ifu_fq_entry_t   fq_head;

  // Circular pointer step for the request-tag FIFO.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FQ_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Request credit, handshake, response routing and queue control.
  always_comb begin
    credit          = (CW1'(outstanding_q) + CW1'(fq_count)) < CW1'(FQ_DEPTH);
    req_valid       = rstn && !bus.pipe_flush && credit;
    req_fire        = req_valid && bus.imem_req_ready;
    rsp_drop        = bus.imem_rsp_valid && (drop_q != '0);
    outstanding_rsp = outstanding_q - CW'(bus.imem_rsp_valid);
    fq_push         = bus.imem_rsp_valid && !rsp_drop && !bus.pipe_flush;
    fq_pop          = bus.instr_valid && !bus.pipe_stall && !bus.pipe_flush;
    fq_push_data.instr = bus.imem_rsp_data;
    fq_push_data.tag   = tag_mem_q[tag_rd_q];
  end

  // Fetch PC, in-flight count and post-flush drop count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q          <= RESET_VECTOR;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      outstanding_q <= outstanding_rsp + CW'(req_fire);
      if (bus.pipe_flush) begin
        pc_q   <= ifu_align(bus.flush_pc);
        drop_q <= outstanding_rsp;
      end else begin
        if (req_fire) pc_q <= pc_q + XLEN'(4);
        if (rsp_drop) drop_q <= drop_q - CW'(1);
      end
    end
  end

  // Request PCs in issue order; every response, kept or dropped, retires one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      for (int i = 0; i < int'(FQ_DEPTH); i++) begin
        tag_mem_q[i] <= '0;
      end
    end else begin
      if (req_fire) begin
        tag_mem_q[tag_wr_q] <= pc_q;
        tag_wr_q            <= ptr_inc(tag_wr_q);
      end
      if (bus.imem_rsp_valid) tag_rd_q <= ptr_inc(tag_rd_q);
    end
  end

  ifu_fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .clk       (clk),
    .rstn      (rstn),
    .push      (fq_push),
    .push_data (fq_push_data),
    .pop       (fq_pop),
    .flush     (bus.pipe_flush),
    .count     (fq_count),
    .head      (fq_head)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.instr          = fq_head.instr;
  assign bus.instr_tag      = fq_head.tag;
  assign bus.instr_valid    = (fq_count != '0);

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: a scripted memory model plus a tag/address scoreboard.
module tb_ifu;
  import ifu_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  ifu_if bus ();
  ifu_if bus2 ();

  ifu dut (.clk(clk), .rstn(rstn), .bus(bus));
  ifu #(.RESET_VECTOR(32'hFFFF_FFF8)) dut_rv (.clk(clk), .rstn(rstn), .bus(bus2));

  int          ncmp = 0;
  int          nfail = 0;
  logic        n_rstn, n_stall, n_flush, n_ready, rsp_en;
  logic        flush_arm, flush_hit, flush_now, found;
  logic [31:0] n_pc;
  logic [31:0] pend[$];
  logic [31:0] pend2[$];
  logic [31:0] exp_next, exp_req;
  logic [31:0] rv_exp [3];
  int          rv_k;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs at negedge, run memory models, then score this cycle.
  task automatic tick();
    @(negedge clk);
    rstn               = n_rstn;
    bus.pipe_stall     = n_stall;
    bus.imem_req_ready = n_ready;
    bus.flush_pc       = n_pc;
    flush_now          = n_flush;
    if (flush_arm && bus.instr_valid && !n_stall && rsp_en && pend.size() > 0) begin
      flush_now = 1'b1;
      flush_arm = 1'b0;
      flush_hit = 1'b1;
    end
    bus.pipe_flush = flush_now;
    if (rsp_en && pend.size() > 0) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(pend.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
    if (pend2.size() > 0) begin
      bus2.imem_rsp_valid = 1'b1;
      bus2.imem_rsp_data  = mem_word(pend2.pop_front());
    end else begin
      bus2.imem_rsp_valid = 1'b0;
      bus2.imem_rsp_data  = '0;
    end
    #1;
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      check("req_addr", bus.imem_req_addr, exp_req);
      exp_req += 32'd4;
      pend.push_back(bus.imem_req_addr);
    end
    if (bus.instr_valid && !bus.pipe_stall && !bus.pipe_flush) begin
      check("pop_tag", bus.instr_tag, exp_next);
      check("pop_instr", bus.instr, mem_word(exp_next));
      exp_next += 32'd4;
    end
    if (flush_now) begin
      exp_next = {n_pc[31:2], 2'b00};
      exp_req  = {n_pc[31:2], 2'b00};
    end
    if (bus2.imem_req_valid) pend2.push_back(bus2.imem_req_addr);
    if (bus2.instr_valid) begin
      if (rv_k < 3) check("rv_tag", bus2.instr_tag, rv_exp[rv_k]);
      rv_k++;
    end
  endtask

  initial begin
    rv_exp[0] = 32'hFFFF_FFF8;
    rv_exp[1] = 32'hFFFF_FFFC;
    rv_exp[2] = 32'h0000_0000;
    rv_k = 0;
    n_rstn = 1'b0; n_stall = 1'b0; n_flush = 1'b0; n_ready = 1'b1; n_pc = '0;
    rsp_en = 1'b1; flush_arm = 1'b0; flush_hit = 1'b0; flush_now = 1'b0;
    exp_next = '0; exp_req = '0;
    rstn = 1'b0;
    bus.pipe_stall = 1'b0; bus.pipe_flush = 1'b0; bus.flush_pc = '0;
    bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus2.pipe_stall = 1'b0; bus2.pipe_flush = 1'b0; bus2.flush_pc = '0;
    bus2.imem_req_ready = 1'b1; bus2.imem_rsp_valid = 1'b0; bus2.imem_rsp_data = '0;

    // Reset state
    tick(); tick();
    check("rst_req_valid", bus.imem_req_valid, 0);
    check("rst_instr_valid", bus.instr_valid, 0);
    check("rst_instr", bus.instr, 0);
    check("rst_tag", bus.instr_tag, 0);
    check("rst_addr", bus.imem_req_addr, 32'h0);
    check("rst_rv_addr", bus2.imem_req_addr, 32'hFFFF_FFF8);

    // First fetches after release: request in cycle 0, instruction visible in cycle 2
    n_rstn = 1'b1;
    tick();
    check("c0_req_valid", bus.imem_req_valid, 1);
    check("c0_addr", bus.imem_req_addr, 32'h0);
    tick();
    check("c1_addr", bus.imem_req_addr, 32'h4);
    check("c1_instr_valid", bus.instr_valid, 0);
    tick();
    check("c2_instr_valid", bus.instr_valid, 1);
    check("c2_tag", bus.instr_tag, 32'h0);
    check("c2_instr", bus.instr, 32'h0000_0013);
    check("c2_no_credit", bus.imem_req_valid, 0);
    repeat (20) tick();

    // Stall with a full queue: no requests, head held, nothing lost afterwards
    n_stall = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_req_valid", bus.imem_req_valid, 0);
      check("stall_valid", bus.instr_valid, 1);
      check("stall_tag", bus.instr_tag, exp_next);
      check("stall_instr", bus.instr, mem_word(exp_next));
    end
    n_stall = 1'b0;
    repeat (10) tick();

    // Memory not ready: address held until a handshake
    n_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("nrdy_addr", bus.imem_req_addr, exp_req);
    end
    check("nrdy_req_valid", bus.imem_req_valid, 1);
    n_ready = 1'b1;
    repeat (6) tick();

    // Flush with two requests in flight
    rsp_en = 1'b0;
    repeat (4) tick();
    check("pre_flush_full", bus.imem_req_valid, 0);
    check("pre_flush_empty", bus.instr_valid, 0);
    n_flush = 1'b1; n_pc = 32'h0000_0103;
    tick();
    check("flush_no_req", bus.imem_req_valid, 0);
    n_flush = 1'b0; rsp_en = 1'b1;
    tick();
    check("flush_instr_valid", bus.instr_valid, 0);
    check("flush_drop_wait", bus.imem_req_valid, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.instr_valid) found = 1'b1;
    end
    check("flush_found", found, 1);
    check("flush_first_tag", bus.instr_tag, 32'h0000_0100);
    repeat (6) tick();

    // Back-to-back flush while stale responses are still being dropped
    rsp_en = 1'b0;
    repeat (4) tick();
    n_flush = 1'b1; n_pc = 32'h0000_0300;
    tick();
    n_pc = 32'h0000_0400; rsp_en = 1'b1;
    tick();
    n_flush = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.instr_valid) found = 1'b1;
    end
    check("reflush_found", found, 1);
    check("reflush_first_tag", bus.instr_tag, 32'h0000_0400);
    repeat (6) tick();

    // Flush coinciding with a response arrival and a pop
    n_pc = 32'h0000_0200; flush_arm = 1'b1;
    for (int i = 0; i < 20 && !flush_hit; i++) tick();
    check("coflush_hit", flush_hit, 1);
    tick();
    check("coflush_instr_valid", bus.instr_valid, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.instr_valid) found = 1'b1;
    end
    check("coflush_found", found, 1);
    check("coflush_first_tag", bus.instr_tag, 32'h0000_0200);
    repeat (8) tick();

    // Wrapping reset vector produced its three tags
    check("rv_pops", (rv_k >= 3) ? 32'd1 : 32'd0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter FQ_DEPTH, default 2, fetch-queue entries and maximum in-flight-plus-buffered instructions.
REQ-003 clk  input  1  sole clock; all flops rising-edge.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_addr  output  XLEN  fetch address, word aligned.
REQ-007 imem_req_ready  input  1  memory accepts request this cycle.
REQ-008 imem_rsp_valid  input  1  in-order response valid, latency >=1 cycle, always accepted.
REQ-009 imem_rsp_data  input  INSTR_LEN  returned instruction word.
REQ-010 pipe_stall  input  1  decode cannot accept; hold head instruction.
REQ-011 pipe_flush  input  1  discard all fetch state; restart at flush_pc.
REQ-012 flush_pc  input  XLEN  redirect target; bits [1:0] ignored.
REQ-013 instr  output  INSTR_LEN  head instruction to decode.
REQ-014 instr_valid  output  1  instr/instr_tag valid.
REQ-015 instr_tag  output  XLEN  PC of instr.

Function
REQ-016 Fetch PC register shall drive imem_req_addr and advance by 4 on each handshake (imem_req_valid & imem_req_ready).
REQ-017 Outstanding counter shall +1 per handshake, -1 per imem_rsp_valid; both in one cycle leaves it unchanged.
REQ-018 imem_req_valid shall be asserted only when outstanding + queue occupancy < FQ_DEPTH and pipe_flush is low, so the queue never overflows.
REQ-019 Non-dropped responses shall push {imem_rsp_data, PC of that request} into the queue; request PCs held in an FQ_DEPTH-entry tag FIFO matched in order.
REQ-020 instr/instr_tag/instr_valid shall be driven from queue head registers; instr_valid = queue not empty; no same-cycle bypass from response to output.
REQ-021 Head shall pop when instr_valid & ~pipe_stall; push and pop in the same cycle shall both take effect, occupancy unchanged.
REQ-022 pipe_stall high shall hold instr, instr_tag, instr_valid stable; requests continue while credit remains.
REQ-023 On pipe_flush: queue emptied and instr_valid low next cycle; PC <= {flush_pc[XLEN-1:2],2'b00}; no request issued in flush cycle.
REQ-024 On pipe_flush, drop counter <= outstanding after that cycle's response; each subsequent response with drop>0 shall be discarded and decrement drop.
REQ-025 Flush while drop>0 shall reload drop from the current outstanding count (no accumulation error).
REQ-026 pipe_flush has priority over pipe_stall and over a same-cycle push or pop.
REQ-027 PC shall wrap modulo 2^XLEN without error.
REQ-028 Best-case latency: request cycle N, response N+1, instr_valid N+2.

Reset
REQ-029 While rstn low: PC=RESET_VECTOR, outstanding=0, drop=0, queue empty, instr_valid=0, instr=0, instr_tag=0, imem_req_valid=0.
REQ-030 Reset assertion mid-operation shall abort all transactions immediately; responses to pre-reset requests are the memory's responsibility to squash.
REQ-031 First request shall be issued in the first clock after rstn deasserts, addr=RESET_VECTOR.

Structure
REQ-032 XLEN and INSTR_LEN shall come from the shared global header; IFU_FQ_DEPTH constant and typedef ifu_fq_entry_t {instr, tag} shall live in the shared types package.
REQ-033 Queue shall be sub-module ifu_fetch_queue (parameterised depth, push/pop/flush, count, head out, async active-low reset); counters and PC stay in ifu.

Verification
REQ-034 Reset release, ready=1, 1-cycle memory returning 32'h00000013 -> addrs 0,4,8...; instr_valid at cycle 2, tags 0,4,8 in order.
REQ-035 pipe_stall high 5 cycles with queue full -> imem_req_valid low, instr/tag unchanged, no lost or duplicate instruction after release.
REQ-036 pipe_flush with 2 requests outstanding, flush_pc=32'h0000_0103 -> both stale responses dropped, next request addr 32'h0000_0100, first instr_tag 32'h0000_0100.
REQ-037 imem_req_ready low 10 cycles -> imem_req_addr held; PC advances only on handshakes.
REQ-038 Flush in same cycle as response arrival and pop -> queue empty, drop = remaining outstanding, no stale instruction emitted.
REQ-039 RESET_VECTOR=32'hFFFF_FFF8 -> tags FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
